// File: rtl/fetch_pc_unit_if.sv
// Fetch PC unit bus: fetch-control request, pipeline controls and imem port.
// pcErr exists only when PC_LIMIT_CHECK_EN is defined.
interface fetch_pc_unit_if;
  logic        fetch;
  logic        extend;
  logic [1:0]  fetchSrc;
  logic        stall;
  logic        branch;
  logic [31:0] branchAddr;
  logic        instrExt;
  logic [15:0] memData;
  logic [31:0] memAddr;
  logic [31:0] pc;
  logic        pcValid;
`ifdef PC_LIMIT_CHECK_EN
  logic        pcErr;
`endif

  modport master (
    output fetch, extend, fetchSrc,
    output stall, branch, branchAddr,
    output instrExt, memData,
    input  memAddr, pc, pcValid
`ifdef PC_LIMIT_CHECK_EN
    , input pcErr
`endif
  );

  modport slave (
    input  fetch, extend, fetchSrc,
    input  stall, branch, branchAddr,
    input  instrExt, memData,
    output memAddr, pc, pcValid
`ifdef PC_LIMIT_CHECK_EN
    , output pcErr
`endif
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// MIPS fetch PC stage: vector load from imem, branch, stall, step.
// Optional PC limit checking enabled by PC_LIMIT_CHECK_EN.
module fetch_pc_unit #(
  parameter int unsigned VEC_BASE  = 0,
  parameter int unsigned MEM_DEPTH = 1048576
) (
  input logic            clk,
  input logic            rst,
  fetch_pc_unit_if.slave bus
);

  typedef enum logic [1:0] {
    RUN,
    VEC_HI,
    VEC_LO
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] vec_q, vec_d;
  logic [15:0] hi_q, hi_d;
  logic        loaded_q, loaded_d;
  logic        pc_wr;
  logic        req;
  logic        over;
  logic [31:0] vec_new;

  assign req     = bus.fetch && bus.extend;
  assign vec_new = 32'(VEC_BASE) + {29'd0, bus.fetchSrc, 1'b0};

`ifdef PC_LIMIT_CHECK_EN
  localparam logic [32:0] LIMIT = 33'(MEM_DEPTH);

  logic err_q, err_d;

  assign over   = {1'b0, pc_q} >= LIMIT;
  assign err_d  = err_q | (pc_wr && ({1'b0, pc_d} >= LIMIT));
  assign bus.pcErr = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end
`else
  assign over = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    vec_d       = vec_q;
    hi_d        = hi_q;
    loaded_d    = loaded_q;
    pc_wr       = 1'b0;
    bus.memAddr = pc_q;
    bus.pcValid = 1'b0;
    unique case (state_q)
      RUN: begin
        bus.pcValid = loaded_q && !bus.stall && !over;
        if (req) begin
          vec_d   = vec_new;
          state_d = VEC_HI;
        end else if (bus.branch) begin
          pc_d  = bus.branchAddr;
          pc_wr = 1'b1;
        end else if (!bus.stall) begin
          pc_d  = pc_q + (bus.instrExt ? 32'd2 : 32'd1);
          pc_wr = 1'b1;
        end
      end
      VEC_HI: begin
        bus.memAddr = vec_q;
        if (req) begin
          vec_d   = vec_new;
          state_d = VEC_HI;
        end else begin
          hi_d    = bus.memData;
          state_d = VEC_LO;
        end
      end
      VEC_LO: begin
        bus.memAddr = vec_q + 32'd1;
        if (req) begin
          vec_d   = vec_new;
          state_d = VEC_HI;
        end else begin
          pc_d     = {hi_q, bus.memData};
          pc_wr    = 1'b1;
          loaded_d = 1'b1;
          state_d  = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= RUN;
      pc_q     <= '0;
      vec_q    <= '0;
      hi_q     <= '0;
      loaded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      vec_q    <= vec_d;
      hi_q     <= hi_d;
      loaded_q <= loaded_d;
    end
  end

  assign bus.pc = pc_q;

endmodule
